// File: rtl/tlb_entry_writer.sv
// -----------------------------------------------------------------------------
// tlb_entry_writer
//
// Takes TLB update beats from the host-facing TLB control slave and commits
// each one into a single set-associative TLB bank. Each beat is handled in
// four steps: read the indexed set, compare the ways, then write or
// invalidate exactly one way. The way is chosen in this order: a hit, then
// the lowest free way, then the round-robin victim.
//
// Ports:
//   aclk, aresetn       clock and synchronous active-low reset
//   s_axis_tdata        update beat: [35:0] VPN, [41:36] pid, [63] v,
//                       [91:64] phost PPN, [119:92] pcard PPN
//   s_axis_tvalid/ready AXI4-Stream handshake; s_axis_tlast is ignored
//   tlb_en, tlb_we      BRAM enable and per-way write enable
//   tlb_addr, tlb_din   BRAM set index and entry {v, pid, tag, phost, pcard}
//   tlb_dout            per-way read data, valid one cycle after a read
//   done                one-cycle pulse per processed beat
//   done_hit            with done: key matched a valid way
//   done_evict          with done: a valid, non-matching entry was replaced
//   n_evict             saturating eviction counter
// -----------------------------------------------------------------------------
module tlb_entry_writer #(
    parameter int TLB_ORDER  = 10,
    parameter int N_ASSOC    = 4,
    parameter int PG_BITS    = 12,
    parameter int VADDR_BITS = 48,
    parameter int PADDR_BITS = 40,
    parameter int PID_BITS   = 6,
    localparam int VPN_BITS   = VADDR_BITS - PG_BITS,
    localparam int PPN_BITS   = PADDR_BITS - PG_BITS,
    localparam int TAG_BITS   = VPN_BITS - TLB_ORDER,
    localparam int ENTRY_BITS = 1 + PID_BITS + TAG_BITS + 2 * PPN_BITS
) (
    input  logic                          aclk,
    input  logic                          aresetn,

    input  logic [127:0]                  s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,

    output logic                          tlb_en,
    output logic [N_ASSOC-1:0]            tlb_we,
    output logic [TLB_ORDER-1:0]          tlb_addr,
    output logic [ENTRY_BITS-1:0]         tlb_din,
    input  logic [N_ASSOC*ENTRY_BITS-1:0] tlb_dout,

    output logic                          done,
    output logic                          done_hit,
    output logic                          done_evict,
    output logic [31:0]                   n_evict
);

    localparam int WAY_W = $clog2(N_ASSOC);

    // Field positions inside the 128-bit update beat
    localparam int BEAT_PID_LSB   = 36;
    localparam int BEAT_V_BIT     = 63;
    localparam int BEAT_PHOST_LSB = 64;
    localparam int BEAT_PCARD_LSB = 92;

    // Field positions inside a stored entry {v, pid, tag, phost, pcard}
    localparam int E_PCARD_LSB = 0;
    localparam int E_PHOST_LSB = PPN_BITS;
    localparam int E_TAG_LSB   = 2 * PPN_BITS;
    localparam int E_PID_LSB   = E_TAG_LSB + TAG_BITS;
    localparam int E_V_BIT     = ENTRY_BITS - 1;

    localparam logic [N_ASSOC-1:0] WAY_ONE = {{(N_ASSOC-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_CMP,
        ST_WRITE
    } state_t;

    state_t                 state_q, state_d;

    // Beat held from acceptance until its write completes
    logic [VPN_BITS-1:0]    vpn_q, vpn_d;
    logic [PID_BITS-1:0]    pid_q, pid_d;
    logic                   v_q, v_d;
    logic [PPN_BITS-1:0]    phost_q, phost_d;
    logic [PPN_BITS-1:0]    pcard_q, pcard_d;

    logic [WAY_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [31:0]            n_evict_q, n_evict_d;

    // All outputs are registered, so a synchronous reset suppresses any
    // write or done that was about to appear in the following cycle.
    logic                   tready_q, tready_d;
    logic                   tlb_en_q, tlb_en_d;
    logic [N_ASSOC-1:0]     tlb_we_q, tlb_we_d;
    logic [TLB_ORDER-1:0]   tlb_addr_q, tlb_addr_d;
    logic [ENTRY_BITS-1:0]  tlb_din_q, tlb_din_d;
    logic                   done_q, done_d;
    logic                   done_hit_q, done_hit_d;
    logic                   done_evict_q, done_evict_d;

    logic [TLB_ORDER-1:0]   beat_index;
    logic [TAG_BITS-1:0]    beat_tag;

    logic                   hit_found;
    logic [WAY_W-1:0]       hit_way;
    logic [ENTRY_BITS-1:0]  hit_entry;
    logic                   free_found;
    logic [WAY_W-1:0]       free_way;
    logic [ENTRY_BITS-1:0]  way_entry;

    logic                   write_sel;
    logic [WAY_W-1:0]       target_way;

    logic                   unused_beat_bits;

    assign unused_beat_bits = ^{s_axis_tlast, s_axis_tdata[62:42], s_axis_tdata[127:120]};

    assign beat_index = vpn_q[TLB_ORDER-1:0];
    assign beat_tag   = vpn_q[VPN_BITS-1:TLB_ORDER];

    // Scan the ways from the highest index down, so that the last assignment
    // leaves the lowest matching or lowest free way selected.
    always_comb begin
        hit_found  = 1'b0;
        hit_way    = '0;
        hit_entry  = '0;
        free_found = 1'b0;
        free_way   = '0;
        way_entry  = '0;
        for (int w = N_ASSOC - 1; w >= 0; w--) begin
            way_entry = tlb_dout[w*ENTRY_BITS +: ENTRY_BITS];
            if (way_entry[E_V_BIT] &&
                (way_entry[E_TAG_LSB +: TAG_BITS] == beat_tag) &&
                (way_entry[E_PID_LSB +: PID_BITS] == pid_q)) begin
                hit_found = 1'b1;
                hit_way   = WAY_W'(w);
                hit_entry = way_entry;
            end
            if (!way_entry[E_V_BIT]) begin
                free_found = 1'b1;
                free_way   = WAY_W'(w);
            end
        end
    end

    // Next-state logic and registered outputs. The memory controls for a
    // state are computed one cycle early, so that they appear while the FSM
    // is in that state.
    always_comb begin
        state_d      = state_q;
        vpn_d        = vpn_q;
        pid_d        = pid_q;
        v_d          = v_q;
        phost_d      = phost_q;
        pcard_d      = pcard_q;
        rr_ptr_d     = rr_ptr_q;
        n_evict_d    = n_evict_q;
        tlb_en_d     = 1'b0;
        tlb_we_d     = '0;
        tlb_addr_d   = '0;
        tlb_din_d    = '0;
        done_d       = 1'b0;
        done_hit_d   = 1'b0;
        done_evict_d = 1'b0;
        write_sel    = 1'b0;
        target_way   = '0;

        case (state_q)
            ST_IDLE: begin
                if (s_axis_tvalid && tready_q) begin
                    vpn_d      = s_axis_tdata[VPN_BITS-1:0];
                    pid_d      = s_axis_tdata[BEAT_PID_LSB +: PID_BITS];
                    v_d        = s_axis_tdata[BEAT_V_BIT];
                    phost_d    = s_axis_tdata[BEAT_PHOST_LSB +: PPN_BITS];
                    pcard_d    = s_axis_tdata[BEAT_PCARD_LSB +: PPN_BITS];
                    tlb_en_d   = 1'b1;
                    tlb_addr_d = s_axis_tdata[TLB_ORDER-1:0];
                    state_d    = ST_READ;
                end
            end

            ST_READ: begin
                state_d = ST_CMP;
            end

            // tlb_dout now holds the set. Decide which way to write and
            // register the complete write for the WRITE cycle.
            ST_CMP: begin
                state_d = ST_WRITE;
                done_d  = 1'b1;
                if (v_q) begin
                    write_sel = 1'b1;
                    tlb_din_d = {1'b1, pid_q, beat_tag, phost_q, pcard_q};
                    if (hit_found) begin
                        target_way = hit_way;
                        done_hit_d = 1'b1;
                    end else if (free_found) begin
                        target_way = free_way;
                    end else begin
                        target_way   = rr_ptr_q;
                        done_evict_d = 1'b1;
                        rr_ptr_d     = rr_ptr_q + 1'b1;
                        if (n_evict_q != '1) begin
                            n_evict_d = n_evict_q + 32'd1;
                        end
                    end
                end else if (hit_found) begin
                    // Invalidation keeps every other field of the stored entry
                    write_sel          = 1'b1;
                    target_way         = hit_way;
                    done_hit_d         = 1'b1;
                    tlb_din_d          = hit_entry;
                    tlb_din_d[E_V_BIT] = 1'b0;
                end
                if (write_sel) begin
                    tlb_en_d   = 1'b1;
                    tlb_we_d   = WAY_ONE << target_way;
                    tlb_addr_d = beat_index;
                end
            end

            ST_WRITE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tready_d = (state_d == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            vpn_q        <= '0;
            pid_q        <= '0;
            v_q          <= 1'b0;
            phost_q      <= '0;
            pcard_q      <= '0;
            rr_ptr_q     <= '0;
            n_evict_q    <= '0;
            tready_q     <= 1'b0;
            tlb_en_q     <= 1'b0;
            tlb_we_q     <= '0;
            tlb_addr_q   <= '0;
            tlb_din_q    <= '0;
            done_q       <= 1'b0;
            done_hit_q   <= 1'b0;
            done_evict_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vpn_q        <= vpn_d;
            pid_q        <= pid_d;
            v_q          <= v_d;
            phost_q      <= phost_d;
            pcard_q      <= pcard_d;
            rr_ptr_q     <= rr_ptr_d;
            n_evict_q    <= n_evict_d;
            tready_q     <= tready_d;
            tlb_en_q     <= tlb_en_d;
            tlb_we_q     <= tlb_we_d;
            tlb_addr_q   <= tlb_addr_d;
            tlb_din_q    <= tlb_din_d;
            done_q       <= done_d;
            done_hit_q   <= done_hit_d;
            done_evict_q <= done_evict_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign tlb_en        = tlb_en_q;
    assign tlb_we        = tlb_we_q;
    assign tlb_addr      = tlb_addr_q;
    assign tlb_din       = tlb_din_q;
    assign done          = done_q;
    assign done_hit      = done_hit_q;
    assign done_evict    = done_evict_q;
    assign n_evict       = n_evict_q;

endmodule

// File: tb/tb_tlb_entry_writer.sv
// -----------------------------------------------------------------------------
// tb_tlb_entry_writer
//
// Directed bench for tlb_entry_writer. A behavioural BRAM with a one-cycle
// read latency sits on the memory port. The bench drives update beats
// through the stream input and compares every cycle of each beat against
// hand-derived values.
// -----------------------------------------------------------------------------
module tb_tlb_entry_writer;

    localparam int E    = 89;
    localparam int NW   = 4;
    localparam int SETS = 1024;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [127:0]    s_axis_tdata;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            s_axis_tlast;
    logic            tlb_en;
    logic [NW-1:0]   tlb_we;
    logic [9:0]      tlb_addr;
    logic [E-1:0]    tlb_din;
    logic [NW*E-1:0] tlb_dout = '0;
    logic            done;
    logic            done_hit;
    logic            done_evict;
    logic [31:0]     n_evict;

    int errors = 0;
    int checks = 0;

    logic [E-1:0] mem [NW][SETS] = '{default: '0};

    tlb_entry_writer dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .tlb_en        (tlb_en),
        .tlb_we        (tlb_we),
        .tlb_addr      (tlb_addr),
        .tlb_din       (tlb_din),
        .tlb_dout      (tlb_dout),
        .done          (done),
        .done_hit      (done_hit),
        .done_evict    (done_evict),
        .n_evict       (n_evict)
    );

    always #5 aclk = ~aclk;

    // Behavioural TLB bank: read-first, one-cycle read latency
    always @(posedge aclk) begin
        if (tlb_en) begin
            for (int w = 0; w < NW; w++) begin
                tlb_dout[w*E +: E] <= mem[w][tlb_addr];
                if (tlb_we[w]) begin
                    mem[w][tlb_addr] <= tlb_din;
                end
            end
        end
    end

    function automatic logic [E-1:0] mkEntry(input logic v, input logic [5:0] pid,
                                             input logic [25:0] tag, input logic [27:0] ph,
                                             input logic [27:0] pc);
        return {v, pid, tag, ph, pc};
    endfunction

    function automatic logic [35:0] mkVpn(input logic [25:0] tag, input logic [9:0] idx);
        return {tag, idx};
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [35:0] vpn, input logic [5:0] pid, input logic v,
                                 input logic [27:0] ph, input logic [27:0] pc);
        s_axis_tdata          = {$urandom, $urandom, $urandom, $urandom};
        s_axis_tdata[35:0]    = vpn;
        s_axis_tdata[41:36]   = pid;
        s_axis_tdata[63]      = v;
        s_axis_tdata[91:64]   = ph;
        s_axis_tdata[119:92]  = pc;
        s_axis_tlast          = 1'($urandom);
        s_axis_tvalid         = 1'b1;
    endtask

    // One beat from acceptance to the IDLE return, checked cycle by cycle
    task automatic runBeat(input string name, input logic [35:0] vpn, input logic [5:0] pid,
                           input logic v, input logic [27:0] ph, input logic [27:0] pc,
                           input logic [NW-1:0] expWe, input logic [E-1:0] expDin,
                           input logic checkDin, input logic expHit, input logic expEvict,
                           input logic [31:0] expNev);
        applyStimulus(vpn, pid, v, ph, pc);
        checkOutput({name, ".tready_T"}, s_axis_tready, 1);
        step();
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
        checkOutput({name, ".rd_en"}, tlb_en, 1);
        checkOutput({name, ".rd_we"}, tlb_we, 0);
        checkOutput({name, ".rd_addr"}, tlb_addr, vpn[9:0]);
        checkOutput({name, ".rd_tready"}, s_axis_tready, 0);
        step();
        checkOutput({name, ".cmp_done"}, done, 0);
        checkOutput({name, ".cmp_en"}, tlb_en, 0);
        step();
        checkOutput({name, ".wr_en"}, tlb_en, |expWe);
        checkOutput({name, ".wr_we"}, tlb_we, expWe);
        if (|expWe) begin
            checkOutput({name, ".wr_addr"}, tlb_addr, vpn[9:0]);
        end
        if (checkDin) begin
            checkOutput({name, ".wr_din"}, tlb_din, expDin);
        end
        checkOutput({name, ".done"}, done, 1);
        checkOutput({name, ".done_hit"}, done_hit, expHit);
        checkOutput({name, ".done_evict"}, done_evict, expEvict);
        checkOutput({name, ".n_evict"}, n_evict, expNev);
        step();
        checkOutput({name, ".tready_T4"}, s_axis_tready, 1);
        checkOutput({name, ".done_clr"}, done, 0);
    endtask

    initial begin
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;

        // Reset state
        step(); step(); step();
        checkOutput("rst.tready", s_axis_tready, 0);
        checkOutput("rst.tlb_en", tlb_en, 0);
        checkOutput("rst.tlb_we", tlb_we, 0);
        checkOutput("rst.tlb_addr", tlb_addr, 0);
        checkOutput("rst.tlb_din", tlb_din, 0);
        checkOutput("rst.done", {done, done_hit, done_evict}, 0);
        checkOutput("rst.n_evict", n_evict, 0);
        aresetn = 1'b1;
        step();
        checkOutput("rst.tready_after", s_axis_tready, 1);

        // Insert into an empty set, then hit the same key
        runBeat("ins", 36'h123, 6'd1, 1'b1, 28'hAAAA, 28'hBBBB, 4'b0001,
                mkEntry(1'b1, 6'd1, 26'd0, 28'hAAAA, 28'hBBBB), 1'b1, 1'b0, 1'b0, 32'd0);
        runBeat("hit", 36'h123, 6'd1, 1'b1, 28'hCCCC, 28'hBBBB, 4'b0001,
                mkEntry(1'b1, 6'd1, 26'd0, 28'hCCCC, 28'hBBBB), 1'b1, 1'b1, 1'b0, 32'd0);

        // Fill set 0x010 with tags 1..4, then two round-robin evictions
        runBeat("fill1", mkVpn(26'd1, 10'h010), 6'd1, 1'b1, 28'h101, 28'h201, 4'b0001,
                mkEntry(1'b1, 6'd1, 26'd1, 28'h101, 28'h201), 1'b1, 1'b0, 1'b0, 32'd0);
        runBeat("fill2", mkVpn(26'd2, 10'h010), 6'd1, 1'b1, 28'h102, 28'h202, 4'b0010,
                mkEntry(1'b1, 6'd1, 26'd2, 28'h102, 28'h202), 1'b1, 1'b0, 1'b0, 32'd0);
        runBeat("fill3", mkVpn(26'd3, 10'h010), 6'd1, 1'b1, 28'h103, 28'h203, 4'b0100,
                mkEntry(1'b1, 6'd1, 26'd3, 28'h103, 28'h203), 1'b1, 1'b0, 1'b0, 32'd0);
        runBeat("fill4", mkVpn(26'd4, 10'h010), 6'd1, 1'b1, 28'h104, 28'h204, 4'b1000,
                mkEntry(1'b1, 6'd1, 26'd4, 28'h104, 28'h204), 1'b1, 1'b0, 1'b0, 32'd0);
        runBeat("evict1", mkVpn(26'd5, 10'h010), 6'd1, 1'b1, 28'h105, 28'h205, 4'b0001,
                mkEntry(1'b1, 6'd1, 26'd5, 28'h105, 28'h205), 1'b1, 1'b0, 1'b1, 32'd1);
        runBeat("evict2", mkVpn(26'd6, 10'h010), 6'd1, 1'b1, 28'h106, 28'h206, 4'b0010,
                mkEntry(1'b1, 6'd1, 26'd6, 28'h106, 28'h206), 1'b1, 1'b0, 1'b1, 32'd2);

        // Invalidate tag 3 (way 2): stored fields are kept, v cleared
        runBeat("inval", mkVpn(26'd3, 10'h010), 6'd1, 1'b0, 28'hDEAD, 28'hBEEF, 4'b0100,
                mkEntry(1'b0, 6'd1, 26'd3, 28'h103, 28'h203), 1'b1, 1'b1, 1'b0, 32'd2);
        runBeat("inval_miss", mkVpn(26'd9, 10'h010), 6'd1, 1'b0, 28'h0, 28'h0, 4'b0000,
                '0, 1'b0, 1'b0, 1'b0, 32'd2);

        // Same tag, different pid is a miss; it takes the freed way 2
        runBeat("pid_miss", mkVpn(26'd4, 10'h010), 6'd2, 1'b1, 28'h114, 28'h214, 4'b0100,
                mkEntry(1'b1, 6'd2, 26'd4, 28'h114, 28'h214), 1'b1, 1'b0, 1'b0, 32'd2);
        runBeat("evict3", mkVpn(26'd7, 10'h010), 6'd1, 1'b1, 28'h107, 28'h207, 4'b0100,
                mkEntry(1'b1, 6'd1, 26'd7, 28'h107, 28'h207), 1'b1, 1'b0, 1'b1, 32'd3);

        // tvalid held for three beats; tdata is scrambled while tready is low
        for (int k = 0; k < 12; k++) begin
            if (k % 4 == 0) begin
                applyStimulus(mkVpn(26'(k / 4 + 1), 10'h020), 6'd3, 1'b1,
                              28'(32'h300 + k / 4), 28'(32'h400 + k / 4));
            end else begin
                s_axis_tdata = {$urandom, $urandom, $urandom, $urandom};
            end
            checkOutput($sformatf("stream.tready%0d", k), s_axis_tready, (k % 4 == 0));
            if (k % 4 == 3) begin
                checkOutput($sformatf("stream.we%0d", k), tlb_we, 4'b0001 << (k / 4));
                checkOutput($sformatf("stream.din%0d", k), tlb_din,
                            mkEntry(1'b1, 6'd3, 26'(k / 4 + 1), 28'(32'h300 + k / 4),
                                    28'(32'h400 + k / 4)));
            end else begin
                checkOutput($sformatf("stream.we%0d", k), tlb_we, 0);
            end
            step();
        end
        s_axis_tvalid = 1'b0;
        checkOutput("stream.idle_tready", s_axis_tready, 1);
        step();
        checkOutput("stream.no_extra", tlb_en, 0);

        // Reset asserted in the CMP cycle
        applyStimulus(mkVpn(26'd1, 10'h030), 6'd1, 1'b1, 28'h5, 28'h6);
        checkOutput("mrst.tready_T", s_axis_tready, 1);
        step();
        s_axis_tvalid = 1'b0;
        step();
        aresetn = 1'b0;
        step();
        checkOutput("mrst.we", tlb_we, 0);
        checkOutput("mrst.en", tlb_en, 0);
        checkOutput("mrst.done", done, 0);
        checkOutput("mrst.tready_low", s_axis_tready, 0);
        checkOutput("mrst.n_evict", n_evict, 0);
        aresetn = 1'b1;
        step();
        checkOutput("mrst.tready_after", s_axis_tready, 1);
        checkOutput("mrst.we_after", tlb_we, 0);
        checkOutput("mrst.done_after", done, 0);

        // Round-robin pointer restarts at way 0 after reset
        runBeat("mrst_rr", mkVpn(26'd8, 10'h010), 6'd1, 1'b1, 28'h108, 28'h208, 4'b0001,
                mkEntry(1'b1, 6'd1, 26'd8, 28'h108, 28'h208), 1'b1, 1'b0, 1'b1, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
